countdown_controller: RTL

//  Sequencer for the down-counter/7-segment display datapath. Turns start/pause/clear

---
 rtl/countdown_controller_pkg.sv | 15 +
 rtl/countdown_controller_tick_prescaler.sv | 26 ++
 rtl/countdown_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/countdown_controller_pkg.sv
// countdown_pkg: shared state encoding and constants for the countdown sequencer.
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam int SYNC_STAGES  = 2;
    localparam int MIN_TICK_DIV = 2;

endpackage

// File: rtl/countdown_controller_tick_prescaler.sv
// tick_prescaler: clock-enable generator, one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && cnt_q == W'(DIV - 1);

    // clr wins over en; a disabled prescaler holds its phase
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_controller.sv
// countdown_controller: turns start/pause/clear keys into counter load/decrement strobes
// paced by a tick enable, and raises an alarm window when the count expires.
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             pause_btn,
    input  logic             clear_btn,
    input  logic [WIDTH-1:0] preset,
    input  logic             cnt_zero,
    output logic             cnt_load,
    output logic             cnt_dec,
    output logic             running,
    output logic             paused,
    output logic             alarm
);

    localparam int DIV = TICK_DIV < MIN_TICK_DIV ? MIN_TICK_DIV : TICK_DIV;
    localparam int AW  = $clog2(ALARM_TICKS + 1);

    state_t                          state_q, state_d;
    logic   [AW-1:0]                 alarm_q, alarm_d;
    logic                            load_q, load_d, dec_q, dec_d;
    logic   [SYNC_STAGES-1:0][2:0]   sync_q;
    logic   [2:0]                    prev_q, ev;
    logic                            clear_ev, start_ev, pause_ev, tick, pre_en, pre_clr;
    logic                            unused_preset;

    // the counter itself consumes preset; the sequencer only strobes it
    assign unused_preset = ^preset;

    assign ev                             = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign {clear_ev, start_ev, pause_ev} = ev;

    assign pre_en  = state_q == RUN || state_q == DONE;
    assign pre_clr = clear_ev || state_q == IDLE || state_q == LOAD;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        dec_d   = 1'b0;
        case (state_q)
            IDLE:  if (start_ev) state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN: begin
                dec_d = tick && !cnt_zero;
                if (pause_ev && !start_ev) state_d = PAUSE;
                else if (tick && cnt_zero) state_d = DONE;
            end
            PAUSE: if (start_ev) state_d = RUN;
            DONE: begin
                if (start_ev) state_d = LOAD;
                else if (tick && alarm_q == AW'(ALARM_TICKS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_ev) begin
            state_d = IDLE;
            dec_d   = 1'b0;
        end
        load_d  = clear_ev || state_d == LOAD;
        // only ticks taken while staying in DONE count toward the alarm window
        alarm_d = (state_q == DONE && state_d == DONE) ? alarm_q + AW'(tick) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            alarm_q <= '0;
            load_q  <= 1'b0;
            dec_q   <= 1'b0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            load_q  <= load_d;
            dec_q   <= dec_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], clear_btn, start_btn, pause_btn};
            prev_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cnt_load = load_q;
    assign cnt_dec  = dec_q;
    assign running  = state_q == RUN;
    assign paused   = state_q == PAUSE;
    assign alarm    = state_q == DONE;

endmodule
